// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and constants for the packet-locked FIFO write arbiter.
// Also hosts the owner-index width helper used by the arbiter family.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    localparam int N_REQ_DEF = 4;
    localparam int WIDTH_DEF = 8;
    localparam int PKT_CNT_W = 16;

    // An index field is never narrower than one bit.
    function automatic int clog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side and FIFO-side signals of the write arbiter.
// The arbiter uses master; producers, FIFO and bench use slave.
interface fifo_wr_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int ID_W  = clog2(N_REQ)
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] req_data;
    logic [N_REQ-1:0]       req_last;
    logic [N_REQ-1:0]       gnt;
    logic                   fifo_full;
    logic                   fifo_wr_en;
    logic [WIDTH-1:0]       fifo_data;
    logic                   busy;
    logic [ID_W-1:0]        owner;
    logic [PKT_CNT_W-1:0]   pkt_cnt;

    modport master (
        input  req, req_data, req_last, fifo_full,
        output gnt, fifo_wr_en, fifo_data,
        output busy, owner, pkt_cnt
    );

    modport slave (
        output req, req_data, req_last, fifo_full,
        input  gnt, fifo_wr_en, fifo_data,
        input  busy, owner, pkt_cnt
    );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after last_owner,
// wrapping cyclically. Shared by the arbiters in this design.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int ID_W  = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  last_owner_i,
    output logic             found_o,
    output logic [ID_W-1:0]  index_o
);
    logic [ID_W-1:0] cand;

    // Walk from the farthest offset inward so the nearest hit wins.
    always_comb begin
        found_o = 1'b0;
        index_o = '0;
        cand    = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = ID_W'((int'(last_owner_i) + k) % N_REQ);
            if (req_i[cand]) begin
                found_o = 1'b1;
                index_o = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-locked arbiter for one FIFO write port.
// A winner keeps the port until its last beat is written.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int ID_W  = clog2(N_REQ)
) (
    input logic               clk,
    input logic               reset_n,
    fifo_wr_arbiter_if.master bus
);
    arb_state_e           state_q, state_d;
    logic [ID_W-1:0]      owner_q, owner_d;
    logic [ID_W-1:0]      last_q, last_d;
    logic [PKT_CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;

    logic                 found;
    logic [ID_W-1:0]      pick;
    logic                 wr_en;
    logic                 last_beat;
    logic [WIDTH-1:0]     slice [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_slice
        assign slice[i] = bus.req_data[i*WIDTH +: WIDTH];
    end

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req_i        (bus.req),
        .last_owner_i (last_q),
        .found_o      (found),
        .index_o      (pick)
    );

    // Grant and write path follow fifo_full in the same cycle.
    always_comb begin
        bus.gnt   = '0;
        wr_en     = 1'b0;
        last_beat = 1'b0;
        if (state_q == LOCK) begin
            bus.gnt[owner_q] = ~bus.fifo_full;
            wr_en     = bus.req[owner_q] & ~bus.fifo_full;
            last_beat = wr_en & bus.req_last[owner_q];
        end
        bus.fifo_wr_en = wr_en;
        bus.fifo_data  = wr_en ? slice[owner_q] : '0;
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        pkt_cnt_d = pkt_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    owner_d = pick;
                    state_d = LOCK;
                end
            end
            LOCK: begin
                if (last_beat) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                    if (pkt_cnt_q != '1) begin
                        pkt_cnt_d = pkt_cnt_q + 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            last_q    <= ID_W'(N_REQ - 1);
            pkt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign bus.busy    = (state_q == LOCK);
    assign bus.owner   = owner_q;
    assign bus.pkt_cnt = pkt_cnt_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (N_REQ=4, WIDTH=8).
// FIFO writes are captured at the falling edge with a cycle stamp.
module tb_fifo_wr_arbiter;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;
    int   cyc;

    logic [7:0] wq[$];
    int         wc[$];

    fifo_wr_arbiter_if #(.N_REQ(4), .WIDTH(8)) bus ();

    fifo_wr_arbiter #(
        .N_REQ (4),
        .WIDTH (8)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (reset_n && bus.fifo_wr_en) begin
            wq.push_back(bus.fifo_data);
            wc.push_back(cyc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if (bus.gnt !== 4'b0000 || bus.fifo_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_out gnt=%b wr=%b want 0000/0",
                     bus.gnt, bus.fifo_wr_en);
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.pkt_cnt !== 16'h0) begin
            errors++;
            $display("FAIL reset_state busy=%b cnt=%h want 0/0000",
                     bus.busy, bus.pkt_cnt);
        end
        checks++;
        if (bus.owner !== 2'd0 || bus.fifo_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_owner owner=%0d data=%h want 0/00",
                     bus.owner, bus.fifo_data);
        end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_round_robin();
        logic [7:0] exp [5];
        exp = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};
        wq.delete();
        wc.delete();
        bus.req      = 4'b1111;
        bus.req_last = 4'b1111;
        bus.req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        checks++;
        if (bus.fifo_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL rr_idle_lat wr=%b want 0", bus.fifo_wr_en);
        end
        repeat (10) step();
        bus.req = 4'b0000;
        checks++;
        if (wq.size() !== 5) begin
            errors++;
            $display("FAIL rr_count got=%0d want 5", wq.size());
        end
        for (int i = 0; i < 5 && i < wq.size(); i++) begin
            checks++;
            if (wq[i] !== exp[i]) begin
                errors++;
                $display("FAIL rr_data[%0d] got=%h want %h", i, wq[i], exp[i]);
            end
        end
        for (int i = 1; i < 5 && i < wc.size(); i++) begin
            checks++;
            if (wc[i] - wc[i-1] !== 2) begin
                errors++;
                $display("FAIL rr_gap[%0d] got=%0d want 2",
                         i, wc[i] - wc[i-1]);
            end
        end
        checks++;
        if (bus.pkt_cnt !== 16'd5 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL rr_cnt cnt=%0d busy=%b want 5/0",
                     bus.pkt_cnt, bus.busy);
        end
    endtask

    task automatic test_packet_lock();
        logic [7:0] exp [4];
        int g1;
        exp = '{8'h11, 8'h12, 8'h13, 8'h21};
        g1 = 0;
        wq.delete();
        bus.req      = 4'b0001;
        bus.req_last = 4'b0000;
        bus.req_data = {8'h00, 8'h00, 8'h00, 8'h11};
        step();
        bus.req      = 4'b0011;
        bus.req_last = 4'b0010;
        bus.req_data = {8'h00, 8'h00, 8'h21, 8'h11};
        #1;
        checks++;
        if (bus.gnt !== 4'b0001) begin
            errors++;
            $display("FAIL lock_gnt got=%b want 0001", bus.gnt);
        end
        if (bus.gnt[1]) g1++;
        step();
        bus.req_data = {8'h00, 8'h00, 8'h21, 8'h12};
        #1;
        if (bus.gnt[1]) g1++;
        step();
        bus.req_data = {8'h00, 8'h00, 8'h21, 8'h13};
        bus.req_last = 4'b0011;
        #1;
        if (bus.gnt[1]) g1++;
        step();
        bus.req = 4'b0010;
        step();
        step();
        bus.req = 4'b0000;
        checks++;
        if (g1 !== 0) begin
            errors++;
            $display("FAIL lock_gnt1 got=%0d cycles want 0", g1);
        end
        checks++;
        if (wq.size() !== 4) begin
            errors++;
            $display("FAIL lock_count got=%0d want 4", wq.size());
        end
        for (int i = 0; i < 4 && i < wq.size(); i++) begin
            checks++;
            if (wq[i] !== exp[i]) begin
                errors++;
                $display("FAIL lock_data[%0d] got=%h want %h",
                         i, wq[i], exp[i]);
            end
        end
        checks++;
        if (bus.pkt_cnt !== 16'd7) begin
            errors++;
            $display("FAIL lock_cnt got=%0d want 7", bus.pkt_cnt);
        end
    endtask

    task automatic test_back_pressure();
        logic [7:0] exp [3];
        exp = '{8'h31, 8'h32, 8'h33};
        wq.delete();
        bus.req      = 4'b0100;
        bus.req_last = 4'b0000;
        bus.req_data = {8'h00, 8'h31, 8'h00, 8'h00};
        bus.fifo_full = 1'b0;
        step();
        step();
        bus.req_data = {8'h00, 8'h32, 8'h00, 8'h00};
        bus.fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (bus.fifo_wr_en !== 1'b0 || bus.gnt !== 4'b0000) begin
                errors++;
                $display("FAIL bp_full[%0d] wr=%b gnt=%b want 0/0000",
                         i, bus.fifo_wr_en, bus.gnt);
            end
            step();
        end
        bus.fifo_full = 1'b0;
        #1;
        checks++;
        if (bus.gnt !== 4'b0100 || bus.fifo_wr_en !== 1'b1) begin
            errors++;
            $display("FAIL bp_resume gnt=%b wr=%b want 0100/1",
                     bus.gnt, bus.fifo_wr_en);
        end
        step();
        bus.req_data = {8'h00, 8'h33, 8'h00, 8'h00};
        bus.req_last = 4'b0100;
        step();
        bus.req = 4'b0000;
        checks++;
        if (wq.size() !== 3) begin
            errors++;
            $display("FAIL bp_count got=%0d want 3", wq.size());
        end
        for (int i = 0; i < 3 && i < wq.size(); i++) begin
            checks++;
            if (wq[i] !== exp[i]) begin
                errors++;
                $display("FAIL bp_data[%0d] got=%h want %h", i, wq[i], exp[i]);
            end
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.pkt_cnt !== 16'd8) begin
            errors++;
            $display("FAIL bp_end busy=%b cnt=%0d want 0/8",
                     bus.busy, bus.pkt_cnt);
        end
    endtask

    task automatic test_owner_stall();
        wq.delete();
        bus.req      = 4'b1000;
        bus.req_last = 4'b0000;
        bus.req_data = {8'h41, 8'h52, 8'h51, 8'h50};
        step();
        bus.req      = 4'b1111;
        bus.req_last = 4'b0111;
        step();
        bus.req = 4'b0111;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (bus.busy !== 1'b1 || bus.owner !== 2'd3 ||
                bus.gnt !== 4'b1000 || bus.fifo_wr_en !== 1'b0) begin
                errors++;
                $display("FAIL stall[%0d] busy=%b own=%0d gnt=%b wr=%b",
                         i, bus.busy, bus.owner, bus.gnt, bus.fifo_wr_en);
            end
            step();
        end
        bus.req      = 4'b1111;
        bus.req_last = 4'b1111;
        bus.req_data = {8'h42, 8'h52, 8'h51, 8'h50};
        step();
        bus.req = 4'b0000;
        checks++;
        if (wq.size() !== 2 || wq[0] !== 8'h41 || wq[1] !== 8'h42) begin
            errors++;
            $display("FAIL stall_data n=%0d want 2 beats 41,42", wq.size());
        end
        checks++;
        if (bus.pkt_cnt !== 16'd9) begin
            errors++;
            $display("FAIL stall_cnt got=%0d want 9", bus.pkt_cnt);
        end
    endtask

    task automatic test_reset_mid_lock();
        bus.req      = 4'b1111;
        bus.req_last = 4'b0000;
        bus.req_data = {8'h63, 8'h62, 8'h61, 8'h60};
        step();
        checks++;
        if (bus.busy !== 1'b1 || bus.fifo_wr_en !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre busy=%b wr=%b want 1/1",
                     bus.busy, bus.fifo_wr_en);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.gnt !== 4'b0000 || bus.fifo_wr_en !== 1'b0 ||
            bus.busy !== 1'b0 || bus.pkt_cnt !== 16'h0) begin
            errors++;
            $display("FAIL rst_async gnt=%b wr=%b busy=%b cnt=%0d",
                     bus.gnt, bus.fifo_wr_en, bus.busy, bus.pkt_cnt);
        end
        step();
        reset_n = 1'b1;
        bus.req_last = 4'b1111;
        step();
        checks++;
        if (bus.owner !== 2'd0 || bus.gnt !== 4'b0001) begin
            errors++;
            $display("FAIL rst_first own=%0d gnt=%b want 0/0001",
                     bus.owner, bus.gnt);
        end
        step();
        bus.req = 4'b0000;
    endtask

    task automatic test_saturation();
        force dut.pkt_cnt_q = 16'hFFFE;
        step();
        step();
        release dut.pkt_cnt_q;
        step();
        checks++;
        if (bus.pkt_cnt !== 16'hFFFE) begin
            errors++;
            $display("FAIL sat_pre got=%h want fffe", bus.pkt_cnt);
        end
        bus.req      = 4'b0001;
        bus.req_last = 4'b0001;
        step();
        step();
        checks++;
        if (bus.pkt_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_top got=%h want ffff", bus.pkt_cnt);
        end
        repeat (4) step();
        bus.req = 4'b0000;
        checks++;
        if (bus.pkt_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_hold got=%h want ffff", bus.pkt_cnt);
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        cyc           = 0;
        reset_n       = 1'b0;
        bus.req       = '0;
        bus.req_last  = '0;
        bus.req_data  = '0;
        bus.fifo_full = 1'b0;
        repeat (2) step();
        test_reset();
        test_round_robin();
        test_packet_lock();
        test_back_pressure();
        test_owner_stall();
        test_reset_mid_lock();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin, packet-locked arbiter that shares the write port of one synchronous FIFO among N_REQ producers.
- A producer wins the port and holds it until it writes a beat flagged last, so packets never interleave in the FIFO.
- The block honours FIFO full back-pressure combinationally.
- It sits between the producer-side modules and the FIFO's data_in/write-enable inputs.

Parameters:
N_REQ, 4, number of requesters (2..16)
WIDTH, 8, data width per beat; must match FIFO WIDTH
ID_W, clog2(N_REQ), width of owner index

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
req  input  N_REQ  per-requester beat valid
req_data  input  N_REQ*WIDTH  packed beat data; requester i at bits [i*WIDTH +: WIDTH]
req_last  input  N_REQ  per-requester last-beat-of-packet flag, qualified by req
gnt  output  N_REQ  one-hot ready; a beat transfers when req[i] & gnt[i]
fifo_full  input  1  full flag from FIFO
fifo_wr_en  output  1  FIFO write enable
fifo_data  output  WIDTH  FIFO write data
busy  output  1  high while a packet lock is held
owner  output  ID_W  index of current lock holder (valid when busy)
pkt_cnt  output  16  completed-packet counter, saturating at 16'hFFFF

Behaviour:
- Clock and reset are fixed: one clock, clk; reset_n is asynchronous and active-low.
- Reset (reset_n=0, asynchronous):
  - state=IDLE, owner=0, last_owner=N_REQ-1 (requester 0 has first priority), pkt_cnt=0.
  - gnt=0, fifo_wr_en=0, busy=0, fifo_data=0.
- Reset asserted mid-packet abandons the lock immediately. Any partial packet already in the FIFO is the system's problem, and the FIFO is reset by the same net.
- State IDLE:
  - gnt=0.
  - If |req, pick the first requester with req=1, searching cyclically from last_owner+1.
  - Register it as owner and go to LOCK. Arbitration latency is one cycle: no beat transfers in the IDLE cycle.
  - If req=0, stay IDLE.
- State LOCK:
  - gnt[owner] = ~fifo_full; all other gnt bits are 0.
  - Combinational: fifo_wr_en = req[owner] & ~fifo_full; fifo_data = req_data slice of owner (0 when fifo_wr_en=0).
  - Beat accepted with req_last[owner]=1: next state IDLE, last_owner<=owner, pkt_cnt++ (saturating).
  - req[owner] deasserted mid-packet: hold LOCK indefinitely (no timeout); other requesters wait.
  - fifo_full=1: no write, gnt=0, state held. Writing resumes in the first cycle fifo_full=0.
- A single-beat packet (req_last set on first beat) takes 2 cycles: IDLE arbitrate, then LOCK write.
- Back-to-back packets from different requesters: 1 idle-arbitration cycle between packets.
- Fairness: with all N_REQ requesting continuously, grant order is 0,1,..,N_REQ-1,0,... No requester waits more than N_REQ-1 packets.
- req/req_last/req_data of non-owners are ignored. req_last without req is ignored.
- busy = (state==LOCK); owner is a register that holds its value in IDLE.
- fifo_wr_en is never asserted when fifo_full=1 (overflow is impossible by construction).

Decomposition:
- Package fifo_arb_pkg: state enum {IDLE, LOCK}, default N_REQ/WIDTH constants, PKT_CNT_W=16, clog2 helper for ID_W.
- One sub-module, rr_pick: combinational round-robin priority picker.
  - Inputs: req vector, last_owner.
  - Outputs: found, index.
  - Reused by other arbiters in the design.

Test Plan:
- Reset: drive reset_n=0 mid-LOCK with req=4'b1111 -> gnt=0, fifo_wr_en=0, busy=0, pkt_cnt=0 immediately, without a clock edge. After release, first grant goes to requester 0.
- Round robin: req=4'b1111, each sends a 1-beat packet with last=1, data=8'hA0+i -> FIFO receives A0,A1,A2,A3,A0. One gap cycle between writes. pkt_cnt=5.
- Packet lock: req0 sends 3 beats 11,12,13 (last on 13) while req1 is asserted -> FIFO order 11,12,13 then req1's beat. gnt[1]=0 throughout req0's packet.
- Back-pressure: fifo_full=1 for 3 cycles during req2's packet -> fifo_wr_en=0 and gnt=0 in those cycles, no beat lost or duplicated. Packet completes after full drops.
- Owner stall: req3 drops req for 5 cycles mid-packet -> busy stays 1, owner=3, no other grant. Packet completes when req3 returns.
- Counter saturation: preload or run 65 536 packets -> pkt_cnt stays at 16'hFFFF.
